// File: rtl/can_rx_pkg.sv
// Shared types and constants for the CAN receive drain path.
// Frame-info word bit positions and frame word indices are reused by the transmit side.
package can_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_RELEASE
  } drain_state_e;

  localparam int INFO_DLC_LSB = 0;
  localparam int INFO_DLC_MSB = 3;
  localparam int INFO_BRS_BIT = 4;
  localparam int INFO_FDF_BIT = 5;
  localparam int INFO_RTR_BIT = 6;
  localparam int INFO_FF_BIT  = 7;
  localparam int INFO_ESI_BIT = 8;

  localparam logic [4:0] WORD_INFO  = 5'd0;
  localparam logic [4:0] WORD_ID    = 5'd1;
  localparam logic [4:0] WORD_DATA0 = 5'd2;

  localparam logic [4:0] MAX_FRAME_WORDS = 5'd18;

endpackage

// File: rtl/can_rx_drain_if.sv
// Valid/ready word stream carrying one received CAN frame at a time.
interface can_rx_drain_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_first;
  logic        m_last;
  logic        m_overrun;

  modport master (output m_valid, m_data, m_first, m_last, m_overrun, input m_ready);
  modport slave  (input m_valid, m_data, m_first, m_last, m_overrun, output m_ready);
endinterface

// File: rtl/can_dlc_words.sv
// Combinational {DLC, FDF, RTR} -> total frame word count (info + id + payload words).
module can_dlc_words
  import can_rx_pkg::*;
(
  input  logic [3:0] dlc,
  input  logic       fdf,
  input  logic       rtr,
  output logic [4:0] words
);

  logic [4:0] payload_words;

  always_comb begin
    payload_words = 5'd0;
    if (!rtr) begin
      if (fdf && (dlc > 4'd8)) begin
        case (dlc)
          4'd9:    payload_words = 5'd3;
          4'd10:   payload_words = 5'd4;
          4'd11:   payload_words = 5'd5;
          4'd12:   payload_words = 5'd6;
          4'd13:   payload_words = 5'd8;
          4'd14:   payload_words = 5'd12;
          default: payload_words = 5'd16;
        endcase
      end else begin
        // Classic frames clamp DLC 9..15 to 8 bytes, which lands in the 2-word bucket
        if (dlc == 4'd0)       payload_words = 5'd0;
        else if (dlc <= 4'd4)  payload_words = 5'd1;
        else                   payload_words = 5'd2;
      end
    end
    words = WORD_DATA0 + payload_words;
  end

endmodule

// File: rtl/can_rx_drain.sv
// Drains stored frames from the receive FIFO into a valid/ready word stream.
// Optional build macro CAN_RX_DRAIN_OVERRUN_DROP_EN discards overrun frames and counts them.
//
// state      | meaning
// ST_IDLE    | waiting for a stored frame; fifo_addr points at word 0
// ST_STREAM  | presenting words of the current frame on the stream
// ST_RELEASE | one-cycle release_buffer pulse freeing the oldest frame
module can_rx_drain
  import can_rx_pkg::*;
#(
  parameter int ADDR_BASE_EXT = 16,
  parameter int ADDR_BASE_STD = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  reset_mode,
  input  logic                  extended_mode,
  input  logic                  info_empty,
  input  logic                  overrun,
  input  logic [31:0]           fifo_data,
  output logic [5:0]            fifo_addr,
  output logic                  release_buffer,
  can_rx_drain_if.master        m,
  output logic [7:0]            drop_cnt
);

  drain_state_e state, state_nxt;
  logic [4:0]   idx, idx_nxt;
  logic [4:0]   total, total_nxt;
  logic         valid_q, valid_nxt;
  logic [31:0]  data_q, data_nxt;
  logic         ovr_q, ovr_nxt;
  logic [4:0]   cap_words;
  logic [5:0]   base;
  logic [4:0]   cur_word;

  can_dlc_words u_dlc_words (
    .dlc   (fifo_data[INFO_DLC_MSB:INFO_DLC_LSB]),
    .fdf   (fifo_data[INFO_FDF_BIT]),
    .rtr   (fifo_data[INFO_RTR_BIT]),
    .words (cap_words)
  );

  assign base      = extended_mode ? 6'(ADDR_BASE_EXT) : 6'(ADDR_BASE_STD);
  // idx always points one word ahead of the word held in data_q
  assign fifo_addr = (state == ST_STREAM) ? (base + {1'b0, idx}) : base;
  assign cur_word  = idx - 5'd1;

  assign m.m_valid   = valid_q;
  assign m.m_data    = data_q;
  assign m.m_overrun = ovr_q;
  assign m.m_first   = (state == ST_STREAM) && (cur_word == WORD_INFO);
  assign m.m_last    = (state == ST_STREAM) && (cur_word == (total - 5'd1));

`ifdef CAN_RX_DRAIN_OVERRUN_DROP_EN
  logic drop_inc;
`endif

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    total_nxt      = total;
    valid_nxt      = valid_q;
    data_nxt       = data_q;
    ovr_nxt        = ovr_q;
    release_buffer = 1'b0;
`ifdef CAN_RX_DRAIN_OVERRUN_DROP_EN
    drop_inc       = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (enable && !info_empty && !reset_mode) begin
`ifdef CAN_RX_DRAIN_OVERRUN_DROP_EN
          if (overrun) begin
            state_nxt = ST_RELEASE;
            drop_inc  = 1'b1;
          end else
`endif
          begin
            data_nxt  = fifo_data;
            ovr_nxt   = overrun;
            total_nxt = cap_words;
            idx_nxt   = WORD_ID;
            valid_nxt = 1'b1;
            state_nxt = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (valid_q && m.m_ready) begin
          if (idx == total) begin
            valid_nxt = 1'b0;
            state_nxt = ST_RELEASE;
          end else begin
            data_nxt = fifo_data;
            idx_nxt  = idx + 5'd1;
          end
        end
      end
      ST_RELEASE: begin
        release_buffer = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset mode abandons any frame in flight; the FIFO flushes itself, so no release
    if (reset_mode) begin
      state_nxt      = ST_IDLE;
      valid_nxt      = 1'b0;
      release_buffer = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      idx     <= 5'd0;
      total   <= 5'd0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      total   <= total_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

`ifdef CAN_RX_DRAIN_OVERRUN_DROP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 8'd0;
    end else if (drop_inc && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: doc/can_rx_drain.md
# can_rx_drain

Receive-side drain engine between the receive FIFO and the host/DMA side of the SJA1000-FD receiver. It detects a stored frame (`info_empty` low) and walks the frame's words through the FIFO's combinational read port. It emits them as a valid/ready word stream with first/last markers, then pulses `release_buffer` exactly once per frame. Word count is derived from the frame-info word, so no FIFO-internal length is needed.

## Interface
Parameters:
- `ADDR_BASE_EXT`, default 16: FIFO read address of word 0 when `extended_mode`=1.
- `ADDR_BASE_STD`, default 20: FIFO read address of word 0 when `extended_mode`=0.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  drain permitted; sampled only in IDLE.
- `reset_mode`  in  1  controller reset mode; synchronous abort.
- `extended_mode`  in  1  selects the address base.
- `info_empty`  in  1  FIFO holds no complete frame.
- `overrun`  in  1  overrun flag of the oldest stored frame.
- `fifo_data`  in  32  FIFO read data; combinational from `fifo_addr`.
- `fifo_addr`  out  6  FIFO read address.
- `release_buffer`  out  1  one-cycle pulse that frees the oldest frame.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  stream sink ready.
- `m_data`  out  32  stream word.
- `m_first`  out  1  current word is word 0.
- `m_last`  out  1  current word is the final word of the frame.
- `m_overrun`  out  1  overrun flag of the current frame, held for the whole frame.
- `drop_cnt`  out  8  count of dropped frames; see Configuration.

## Operation
- Word 0 (frame info) layout:
  - [3:0] DLC.
  - [4] BRS.
  - [5] FDF.
  - [6] RTR.
  - [7] FF (1 = extended ID).
  - [8] ESI.
  - [31:9] zero.
- Word 1 is the identifier, right-aligned: 11 or 29 bits.
- Words 2 and up are payload, little-endian bytes; the last word is zero-padded.
- Payload bytes:
  - RTR=1: 0 bytes.
  - FDF=0: min(DLC, 8).
  - FDF=1, DLC 0–8: DLC bytes.
  - FDF=1, DLC 9–15: 12, 16, 20, 24, 32, 48, 64 bytes respectively.
- Word total = 2 + ceil(bytes/4), giving a range of 2..18 words.
- Addressing: `fifo_addr` = base + idx, modulo 64 (6-bit wrap). The base is selected by `extended_mode`.
- FSM states are IDLE, STREAM and RELEASE.
- IDLE:
  - `fifo_addr` = base.
  - If `enable` & ~`info_empty` & ~`reset_mode`:
    - `m_data` <= `fifo_data`.
    - `m_overrun` <= `overrun`.
    - total is computed from `fifo_data`.
    - idx <= 1.
    - `m_valid` <= 1.
    - Go to STREAM.
- STREAM:
  - `fifo_addr` = base + idx.
  - On `m_valid` & `m_ready`:
    - If the current word is last: `m_valid` <= 0 and go to RELEASE.
    - Otherwise: `m_data` <= `fifo_data` and idx <= idx + 1.
- RELEASE: `release_buffer` = 1 for this cycle only, then go to IDLE.
- `m_first` = STREAM & (word number == 0).
- `m_last` = STREAM & (word number == total − 1).
- `m_data`, `m_overrun` and `m_valid` are registered. `m_data` holds stable while `m_valid` & ~`m_ready`.
- `reset_mode` high, in any state:
  - Next state is IDLE and `m_valid` <= 0.
  - No `release_buffer` pulse is issued; the FIFO flushes itself.
  - A partially sent frame is abandoned without `m_last`.
- Reset values:
  - state IDLE.
  - `m_valid`, `m_first`, `m_last`, `m_overrun`, `release_buffer` all 0.
  - `m_data` 0.
  - `drop_cnt` 0.
  - `fifo_addr` = base.

## Timing
- `m_valid` rises 1 cycle after the first IDLE cycle that sees `info_empty`=0.
- With `m_ready` held high, a frame of N words occupies N+2 cycles: capture, N beats, release.
- `release_buffer` is asserted in the cycle after the `m_last` handshake.
- The FIFO updates its pointers at the edge ending the release cycle. The next IDLE cycle therefore sees the updated `info_empty`, and back-to-back frames need no extra gap.
- Backpressure stalls indefinitely; there is no timeout.

## Configuration
- `CAN_RX_DRAIN_OVERRUN_DROP_EN` defined:
  - A frame whose `overrun`=1 at capture is not streamed.
  - The FSM goes IDLE → RELEASE directly and `drop_cnt` increments, saturating at 255.
- Macro not defined:
  - Overrun frames are streamed normally with `m_overrun`=1.
  - `drop_cnt` is tied to 0.

## Structure
- Package `can_rx_pkg` holds:
  - The state enum.
  - Word-0 bit-position constants.
  - The word indices (INFO=0, ID=1, DATA0=2).
  - The max frame word count (18).
- Sub-module `can_dlc_words` is combinational: {DLC, FDF, RTR} → 5-bit word total. The lookup is shared with the transmit path.

## Test plan
- Classic frame, `m_ready`=1: word0=0x00000003, ID=0x123, data=0x00CCBBAA → 3 beats; `m_first` on beat 0 and `m_last` on beat 2; `release_buffer` pulses once; 5 cycles total.
- FD frame, word0=0x0000003F (FDF, BRS, DLC15) → 18 beats; the addresses wrap correctly when the base plus offset crosses 63.
- RTR frame, word0=0x00000048 (RTR, DLC8) → 2 beats only, then release.
- Random `m_ready` (≈50%) over 20 frames → `m_data` stable while stalled; stream equals the FIFO contents; release count equals 20.
- `reset_mode` asserted at beat 4 of 10 → `m_valid` drops the next cycle; no release; after reset_mode clears, the engine returns to IDLE and accepts a new frame.
- Overrun frame: with the macro, → 0 beats, 1 release, `drop_cnt`=1. Without it, → streamed with `m_overrun`=1. `extended_mode`=0 → first `fifo_addr`=20.
